seg_scroll_ctrl: RTL and testbench
==================================

// Module: seg_scroll_ctrl
// PURPOSE
//   Parametrised scrolling driver for a bank of N_DIGITS 7-segment displays.
//   Displays a hex/blank message of up to DEPTH characters, stepping one position every CLK_NUM cycles, left or right.
//   Message is written through a double-buffered valid/ready port and committed atomically on a step boundary.
//   Sits between the board top-level (o_seg bus to the display pins) and whatever control logic composes messages.
// PARAMETERS
//   N_DIGITS  8          number of physical digits; >=1
//   DEPTH     16         message buffer entries; power of 2, >=N_DIGITS
//   CLK_NUM   5000000    clk cycles per scroll step; >=2
//   LW        $clog2(DEPTH)  localparam, buffer address width
// PORTS
//   clk        in   1            system clock, all state on posedge
//   rst_n      in   1            asynchronous active-low reset
//   en         in   1            1 = step counter runs; 0 = counter and offset frozen
//   dir        in   1            0 = scroll left (offset+1), 1 = scroll right (offset-1)
//   wr_valid   in   1            shadow-buffer write request
//   wr_ready   out  1            shadow buffer accepting writes
//   wr_addr    in   LW           shadow entry index
//   wr_data    in   5            [4]=blank flag, [3:0]=hex digit
//   commit     in   1            pulse: request shadow->active copy
//   msg_len    in   LW+1         message length used at commit, 0..DEPTH
//   o_seg      out  8*N_DIGITS   digit i on [8*i+7:8*i]; bit7..1 = a..g, bit0 = dp; active-low
//   step       out  1            1-cycle pulse on every scroll step
//   wrap       out  1            1-cycle pulse when offset wraps
// BEHAVIOUR
//   Reset (async, immediate): active and shadow buffers all blank, len=0, offset=0, count=0, pending=0.
//     o_seg = all 1s (all digits dark), step=0, wrap=0, wr_ready=1.
//   Counter: if en, count increments; at count==CLK_NUM-1, count->0 and step=1 for that cycle.
//     en=0 holds count.
//   Offset: on step with len>N_DIGITS:
//     dir=0: offset = (offset==len-1) ? 0 : offset+1;
//     dir=1: offset = (offset==0) ? len-1 : offset-1.
//     wrap=1 in the same cycle as the wrapping step.
//     len<=N_DIGITS: offset stays 0, no wrap.
//   Display (combinational from registered state, no extra latency):
//     idx_i = offset+i; if idx_i>=len subtract len; exactly one conditional subtract, valid since offset<len.
//     Digit i is blank when i>=len, otherwise glyph(active[idx_i]).
//     blank flag -> 8'hFF; hex 0-F -> standard glyph; dp always off (bit0=1).
//   Write port: accepted when wr_valid && wr_ready; shadow[wr_addr] <= wr_data next edge.
//   Commit: commit sets pending.
//     wr_ready = !pending; writes are dropped while pending, and the master must hold them.
//     Pending resolves on the next step, or on the next cycle if en=0:
//       active <= shadow (whole array), len <= min(msg_len,DEPTH), offset <= 0, pending <= 0.
//     That step does not also advance offset, and wrap=0.
//   Simultaneous events:
//     - commit while pending: ignored.
//     - commit in the same cycle as an accepted write: the write lands in shadow before the copy.
//     - dir change mid-run: takes effect on the next step.
//   msg_len=0 at commit: all digits blank, counter keeps running, step still pulses.
// STRUCTURE
//   seg_pkg:
//     - SEG_BLANK = 8'hFF
//     - typedef seg_t (logic [7:0])
//     - typedef chr_t (logic [4:0])
//     - function/const table of the 16 hex glyphs
//   Sub-module seg_hex_decode (chr_t -> seg_t, combinational), instantiated N_DIGITS times.
//   Top holds: counter, offset, pending FSM (IDLE/PENDING), shadow + active arrays.
// TESTING (CLK_NUM=4, N_DIGITS=4, DEPTH=8)
//   1. Reset, idle:
//      rst_n low mid-run -> o_seg=32'hFFFFFFFF at once, wr_ready=1; then step every 4th cycle, no wrap.
//   2. Write+commit:
//      write 0..5 to addr 0..5, commit, msg_len=6 -> o_seg shows 0,1,2,3 (digit0..3) after the next step.
//   3. Scroll left:
//      after test 2, 6 steps -> offsets 1,2,3,4,5,0.
//      Offset 4 shows 4,5,0,1; wrap pulses at the step to 0.
//   4. Scroll right:
//      dir=1 from offset 0 -> next step offset=5 with wrap=1; display 5,0,1,2.
//   5. Handshake:
//      commit with en=1, then wr_valid held -> wr_ready=0 until step, write accepted the cycle after commit completes.
//      A second commit while pending is ignored.
//   6. Short message/freeze:
//      msg_len=2 -> digits 2,3 blank, offset fixed 0.
//      en=0 -> count frozen, commit completes in 1 cycle.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg_pkg
// Brief  : Shared types, blank glyph and hex glyph table for the scroll driver.
// Rev    : 1.0
// ============================================================================
package seg_pkg;

    typedef logic [7:0] seg_t;
    typedef logic [4:0] chr_t;

    localparam seg_t SEG_BLANK = 8'hFF;
    localparam chr_t CHR_BLANK = 5'h10;

    // Active-low {a,b,c,d,e,f,g,dp}; dp held off.
    function automatic seg_t hex_glyph(input logic [3:0] hex);
        seg_t g;
        g = SEG_BLANK;
        case (hex)
            4'h0: g = 8'h03;
            4'h1: g = 8'h9F;
            4'h2: g = 8'h25;
            4'h3: g = 8'h0D;
            4'h4: g = 8'h99;
            4'h5: g = 8'h49;
            4'h6: g = 8'h41;
            4'h7: g = 8'h1F;
            4'h8: g = 8'h01;
            4'h9: g = 8'h09;
            4'hA: g = 8'h11;
            4'hB: g = 8'hC1;
            4'hC: g = 8'h63;
            4'hD: g = 8'h85;
            4'hE: g = 8'h61;
            4'hF: g = 8'h71;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module : seg_hex_decode
// Brief  : Character (blank flag + hex nibble) to active-low 7-segment glyph.
// Rev    : 1.0
// ============================================================================
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [4:0] chr,
    output logic [7:0] seg
);

    assign seg = chr[4] ? SEG_BLANK : hex_glyph(chr[3:0]);

endmodule
`default_nettype wire

// File: rtl/seg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seg_scroll_ctrl
// Brief  : Scrolling 7-segment driver with double-buffered message commit.
// Rev    : 1.0
// ============================================================================
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter  int N_DIGITS = 8,
    parameter  int DEPTH    = 16,
    parameter  int CLK_NUM  = 5000000,
    localparam int LW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [LW-1:0]         wr_addr,
    input  logic [4:0]            wr_data,
    input  logic                  commit,
    input  logic [LW:0]           msg_len,
    output logic [8*N_DIGITS-1:0] o_seg,
    output logic                  step,
    output logic                  wrap
);

    localparam int         CW         = $clog2(CLK_NUM);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          w_resolve;
    logic [CW-1:0] r_count;
    logic [LW-1:0] r_offset;
    logic [LW-1:0] w_offset_nxt;
    logic [LW:0]   r_len;
    logic [LW:0]   w_len_clamp;
    logic          w_scroll;
    logic          w_at_end;
    logic          w_wr_fire;
    chr_t          r_shadow [DEPTH];
    chr_t          r_active [DEPTH];

    assign step        = en && (r_count == CW'(CLK_NUM - 1));
    assign wr_ready    = (r_state == ST_IDLE);
    assign w_wr_fire   = wr_valid && wr_ready;
    assign w_len_clamp = (msg_len > (LW+1)'(DEPTH)) ? (LW+1)'(DEPTH) : msg_len;
    assign w_scroll    = r_len > (LW+1)'(N_DIGITS);
    assign w_at_end    = dir ? (r_offset == '0) : ({1'b0, r_offset} == r_len - 1'b1);
    assign w_offset_nxt = dir ? (w_at_end ? LW'(r_len - 1'b1) : r_offset - 1'b1)
                              : (w_at_end ? '0 : r_offset + 1'b1);
    // The commit step only reloads the message; it never advances or wraps.
    assign wrap        = step && w_scroll && w_at_end && !w_resolve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_resolve   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (commit) w_state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                if (step || !en) begin
                    w_resolve   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_offset <= '0;
            r_len    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_shadow[k] <= CHR_BLANK;
                r_active[k] <= CHR_BLANK;
            end
        end else begin
            if (en) r_count <= step ? '0 : r_count + 1'b1;
            if (w_wr_fire) r_shadow[wr_addr] <= wr_data;
            if (w_resolve) begin
                r_active <= r_shadow;
                r_len    <= w_len_clamp;
                r_offset <= '0;
            end else if (step && w_scroll) begin
                r_offset <= w_offset_nxt;
            end
        end
    end

    // offset < len, so one conditional subtract brings offset+i back into range.
    generate
        for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
            logic [LW:0]   w_idx_raw;
            logic [LW-1:0] w_sel;
            chr_t          w_chr;
            assign w_idx_raw = {1'b0, r_offset} + (LW+1)'(i);
            assign w_sel     = (w_idx_raw >= r_len) ? LW'(w_idx_raw - r_len) : LW'(w_idx_raw);
            assign w_chr     = ((LW+1)'(i) < r_len) ? r_active[w_sel] : CHR_BLANK;
            seg_hex_decode u_dec (
                .chr (w_chr),
                .seg (o_seg[8*i +: 8])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_seg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_seg_scroll_ctrl
// Brief  : Directed self-checking bench for seg_scroll_ctrl (4 digits, depth 8).
// Rev    : 1.0
// ============================================================================
module tb_seg_scroll_ctrl;

    localparam int N_DIGITS = 4;
    localparam int DEPTH    = 8;
    localparam int CLK_NUM  = 4;
    localparam int LW       = 3;
    localparam logic [7:0] GLY [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    logic        clk = 1'b0;
    logic        rst_n, en, dir, wr_valid, wr_ready, commit, step, wrap;
    logic [2:0]  wr_addr;
    logic [4:0]  wr_data;
    logic [3:0]  msg_len;
    logic [31:0] o_seg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    seg_scroll_ctrl #(.N_DIGITS(N_DIGITS), .DEPTH(DEPTH), .CLK_NUM(CLK_NUM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .msg_len  (msg_len),
        .o_seg    (o_seg),
        .step     (step),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] g(input int x);
        return (x < 0) ? 8'hFF : GLY[x];
    endfunction

    // Digit 0 in the low byte; -1 means blank.
    function automatic logic [31:0] exp4(input int d0, input int d1, input int d2, input int d3);
        return {g(d3), g(d2), g(d1), g(d0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge where step is high; returns cycles taken.
    task automatic wait_step(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!step && cycles < 20);
        if (!step) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: step timeout observed 0 expected 1", tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 1'b0; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0; commit = 1'b0; msg_len = '0;

        // Reset state
        @(negedge clk);
        check("rst_seg", o_seg, 32'hFFFF_FFFF);
        check("rst_ready", {31'b0, wr_ready}, 32'd1);
        check("rst_step_wrap", {30'b0, step, wrap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;

        // Idle stepping: first step after 3 edges, then every 4
        wait_step("idle1", cyc);
        check("idle_first_step", cyc, 32'd3);
        wait_step("idle2", cyc);
        check("idle_period", cyc, 32'd4);
        check("idle_wrap", {31'b0, wrap}, 32'd0);
        check("idle_seg", o_seg, 32'hFFFF_FFFF);

        // Write 0..5 then commit with length 6
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 5'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0; commit = 1'b1; msg_len = 4'd6;
        @(negedge clk);
        commit = 1'b0;
        check("commit_pending_ready", {31'b0, wr_ready}, 32'd0);
        wait_step("commit", cyc);
        check("commit_old_seg", o_seg, 32'hFFFF_FFFF);
        check("commit_wrap", {31'b0, wrap}, 32'd0);
        @(negedge clk);
        check("commit_seg", o_seg, exp4(0, 1, 2, 3));
        check("commit_ready", {31'b0, wr_ready}, 32'd1);

        // Scroll left through offsets 1..5,0
        for (int k = 1; k <= 6; k++) begin
            wait_step("left", cyc);
            check($sformatf("left_wrap_%0d", k), {31'b0, wrap}, (k == 6) ? 32'd1 : 32'd0);
            @(negedge clk);
            check($sformatf("left_seg_%0d", k % 6), o_seg,
                  exp4(k % 6, (k + 1) % 6, (k + 2) % 6, (k + 3) % 6));
        end

        // Scroll right from offset 0
        dir = 1'b1;
        wait_step("right1", cyc);
        check("right_wrap", {31'b0, wrap}, 32'd1);
        @(negedge clk);
        check("right_seg5", o_seg, exp4(5, 0, 1, 2));
        wait_step("right2", cyc);
        check("right_nowrap", {31'b0, wrap}, 32'd0);
        @(negedge clk);
        check("right_seg4", o_seg, exp4(4, 5, 0, 1));

        // Handshake: writes held off while pending, second commit ignored
        dir = 1'b0; commit = 1'b1;
        @(negedge clk);
        check("hs_ready_low1", {31'b0, wr_ready}, 32'd0);
        commit = 1'b1; wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 5'h0A;
        @(negedge clk);
        commit = 1'b0;
        check("hs_ready_low2", {31'b0, wr_ready}, 32'd0);
        wait_step("hs", cyc);
        check("hs_ready_at_step", {31'b0, wr_ready}, 32'd0);
        check("hs_wrap", {31'b0, wrap}, 32'd0);
        @(negedge clk);
        check("hs_ready_high", {31'b0, wr_ready}, 32'd1);
        check("hs_seg_reload", o_seg, exp4(0, 1, 2, 3));
        @(negedge clk);
        wr_valid = 1'b0;
        check("hs_second_commit_ignored", {31'b0, wr_ready}, 32'd1);
        wait_step("hs2", cyc);
        @(negedge clk);
        check("hs_active_unchanged", o_seg, exp4(1, 2, 3, 4));
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        wait_step("hs3", cyc);
        @(negedge clk);
        check("hs_write_landed", o_seg, exp4(10, 1, 2, 3));

        // Short message: offset pinned at 0
        msg_len = 4'd2; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        wait_step("short1", cyc);
        @(negedge clk);
        check("short_seg", o_seg, exp4(10, 1, -1, -1));
        wait_step("short2", cyc);
        check("short_nowrap", {31'b0, wrap}, 32'd0);
        @(negedge clk);
        check("short_seg_fixed", o_seg, exp4(10, 1, -1, -1));

        // Freeze: counter holds at its terminal value, commit resolves in one cycle
        wait_step("freeze", cyc);
        en = 1'b0;
        #1;
        check("freeze_step_off", {31'b0, step}, 32'd0);
        repeat (5) @(negedge clk);
        check("freeze_no_step", {31'b0, step}, 32'd0);
        msg_len = 4'd3; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check("freeze_pending", {31'b0, wr_ready}, 32'd0);
        @(negedge clk);
        check("freeze_resolved", {31'b0, wr_ready}, 32'd1);
        check("freeze_seg", o_seg, exp4(10, 1, 2, -1));
        en = 1'b1;
        #1;
        check("freeze_count_held", {31'b0, step}, 32'd1);
        @(negedge clk);

        // Zero-length message: all dark, counter keeps stepping
        msg_len = 4'd0; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        wait_step("zero1", cyc);
        @(negedge clk);
        check("zero_seg", o_seg, 32'hFFFF_FFFF);
        wait_step("zero2", cyc);
        check("zero_step_period", cyc, 32'd3);

        // Mid-run asynchronous reset with a lit display
        en = 1'b0; msg_len = 4'd6; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        @(negedge clk);
        check("pre_reset_seg", o_seg, exp4(10, 1, 2, 3));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", o_seg, 32'hFFFF_FFFF);
        check("async_rst_ready", {31'b0, wr_ready}, 32'd1);
        en = 1'b1;
        #1;
        check("async_rst_count", {31'b0, step}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
